pipe_stage_elastic: RTL

//  Parametrised pipeline-stage register; successor to the fixed 32b IF/ID latch.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_stage_elastic.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for elastic pipeline stages.
// State encoding doubles as the occupancy count.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic NOP_FILL = 1'b0;

  function automatic logic [1:0] pop2(
    input logic a,
    input logic b
  );
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; adds 0..3 per enabled cycle.
// Sticks at the all-ones value once reached.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [1:0]   add_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W:0] MAX = {1'b0, {W{1'b1}}};

  logic [W-1:0] cnt_q;
  logic [W:0]   sum;

  assign sum   = {1'b0, cnt_q} + (W+1)'(add_i);
  assign cnt_o = cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      if (sum > MAX) cnt_q <= MAX[W-1:0];
      else           cnt_q <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with 2-entry skid buffer,
// legacy stall/flush controls and a squash counter.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int              DATA_W           = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE      = {DATA_W{NOP_FILL}},
  parameter bit              FLUSH_OVER_STALL = 1'b0,
  parameter int              CNT_W            = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  squash_cnt_o
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_v, skid_v;
  logic              stl, fl;
  logic              push, pop;

  assign main_v = (state_q != EMPTY);
  assign skid_v = (state_q == FULL);

  assign fl  = FLUSH_OVER_STALL ? flush_i
                                : (flush_i & ~stall_i);
  assign stl = FLUSH_OVER_STALL ? (stall_i & ~flush_i)
                                : stall_i;

  // ready depends only on registered state and controls
  assign up_ready_o = (state_q != FULL) & ~stl;
  assign dn_valid_o = main_v & ~stl;
  assign dn_data_o  = main_q;
  assign occ_o      = state_q;

  assign push = up_valid_i & up_ready_o & ~fl;
  assign pop  = dn_valid_o & dn_ready_i & ~fl;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (fl) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = up_data_i;
          end
        end
        ONE: begin
          unique case (1'b1)
            push & pop:  main_d = up_data_i;
            push & ~pop: begin
              state_d = FULL;
              skid_d  = up_data_i;
            end
            pop & ~push: state_d = EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= NOP_VALUE;
      skid_q  <= NOP_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_squash (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (fl),
    .add_i   (pop2(main_v, skid_v)),
    .cnt_o   (squash_cnt_o)
  );

endmodule
